matmul_operand_sequencer: RTL
=============================

Name: matmul_operand_sequencer

Overview:
- Operand store and streaming controller that drives the 3x3 MAC array.
- Buffers two 3x3 operand matrices, W and X, loaded element by element over a simple write port.
- On `start`, clears the array, then streams W columns and X rows over 3 cycles so the array accumulates C = W*X.
- Acts as the writer/driver end of the array's `data_w*`/`data_x*`/`load`/`clear` interface.

Parameters:
- `DATA_W`, default 4: operand element width; must match the array input width.
- `SETTLE`, default 2: idle cycles after the last load beat, before `done`, covering array accumulator latency. Range 0..15.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `clear` in 1: synchronous, active-high reset.
- `wr_en` in 1: write one operand element this cycle.
- `wr_sel` in 1: 0 = matrix W, 1 = matrix X.
- `wr_addr` in 4: element index row*3+col; legal range 0..8.
- `wr_data` in DATA_W: element value, unsigned.
- `wr_err` out 1: registered one-cycle pulse when a write is rejected.
- `start` in 1: begin a multiply run; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `data_w1`, `data_w2`, `data_w3` out DATA_W each: W column beat, element i = W[i][k].
- `data_x1`, `data_x2`, `data_x3` out DATA_W each: X row beat, element j = X[k][j].
- `mac_load` out 1: array accumulate enable.
- `mac_clear` out 1: array accumulator clear.

Behaviour:
- Reset (`clear`=1 at an edge):
  - FSM goes to IDLE.
  - All 18 store elements become 0.
  - All outputs are 0 in the following cycle.
  - Reset has priority over every other input.
- All outputs are registered.
- `data_*` outputs are 0 whenever `mac_load`=0.
- Write port:
  - Accepted only in IDLE with `wr_addr` <= 8; updates W[wr_addr/3][wr_addr%3] or X[...] at the edge.
  - `wr_addr` > 8 → store unchanged, `wr_err`=1 next cycle.
  - Write while `busy` → store unchanged, `wr_err`=1 next cycle.
- FSM states:
  - IDLE: `start`=1 at edge T → CLR.
  - CLR (cycle T+1): `mac_clear`=1, `mac_load`=0.
  - STREAM (cycles T+2..T+4): beat counter k = 0, 1, 2; `mac_load`=1; `data_w`/`data_x` as defined above. Counter saturates at 2, then goes to SETTLE (or DONE if SETTLE=0).
  - SETTLE: SETTLE cycles with `mac_load`=0.
  - DONE (cycle T+5+SETTLE): `done`=1, `busy`=1, then IDLE.
- Total latency from `start` edge to `done`: 5+SETTLE cycles.
- `start` while busy is ignored; no error, no queueing.
- `wr_en` and `start` in the same IDLE cycle: the write commits at that edge and the run uses the updated value.
- Reset mid-run: next cycle IDLE, `mac_load`=0, `done` never pulses. Partial array contents are harmless because every run begins with CLR.
- Arithmetic: the sequencer does none. With DATA_W=4 the array result is at most 3*15*15 = 675, which fits the array's 10-bit accumulators.

Optional Feature:
- Macro: `MATSEQ_TRANSPOSE_EN`.
- When defined:
  - Extra input port `x_transpose` (1 bit), sampled with `start` in IDLE and held for the run.
  - When 1, stream beat k drives `data_x_j` = X[j][k], so the array computes W*X^T.
  - When 0, normal streaming.
- When undefined: port absent, always normal streaming, no extra logic.

Test Plan:
- Identity W, X = 1..9 row-major, SETTLE=2, start at T:
  - `mac_clear` at T+1.
  - Beats: k0 w=(1,0,0) x=(1,2,3); k1 w=(0,1,0) x=(4,5,6); k2 w=(0,0,1) x=(7,8,9).
  - `done` at T+7.
  - With array attached, o11..o33 = 1..9.
- All 18 elements = 15: every beat shows 15 on all six data outputs; array results all 675; `busy` high T+1..T+7.
- Write during busy, and `start` during busy:
  - `wr_err` pulses one cycle.
  - The second `start` is ignored (exactly one `done`).
  - A rerun streams the original values.
- `wr_addr`=9 and `wr_addr`=15 writes in IDLE: `wr_err`=1 each; store unchanged, verified by run output.
- Assert `clear` during beat k=1:
  - Next cycle all outputs 0, `busy`=0, no `done`.
  - The following run streams all zeros.
- With `MATSEQ_TRANSPOSE_EN` and `x_transpose`=1, X = 1..9:
  - Beats x=(1,4,7), (2,5,8), (3,6,9).
  - With identity W, array result = X^T.

Source files
------------

// File: rtl/matmul_operand_sequencer.sv
// matmul_operand_sequencer: buffers 3x3 operands W and X and streams them into the 3x3 MAC array.
// Define MATSEQ_TRANSPOSE_EN to add the x_transpose input, which streams X^T instead of X.
module matmul_operand_sequencer #(
   parameter int DATA_W = 4,
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              wr_en,
   input  logic              wr_sel,
   input  logic [3:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
`ifdef MATSEQ_TRANSPOSE_EN
   input  logic              x_transpose,
`endif
   output logic              wr_err,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] data_w1,
   output logic [DATA_W-1:0] data_w2,
   output logic [DATA_W-1:0] data_w3,
   output logic [DATA_W-1:0] data_x1,
   output logic [DATA_W-1:0] data_x2,
   output logic [DATA_W-1:0] data_x3,
   output logic              mac_load,
   output logic              mac_clear
);
   localparam logic [2:0] IDLE = 3'd0, CLR = 3'd1, STREAM = 3'd2, SETL = 3'd3, DONE = 3'd4;
   localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);
   logic [2:0] state, ns;
   logic [1:0] k, nk;
   logic [3:0] cnt, ncnt;
   logic [DATA_W-1:0] w [3][3];
   logic [DATA_W-1:0] x [3][3];
   logic [DATA_W-1:0] nx1, nx2, nx3;
   logic [1:0] wr_row, wr_col;
   logic wr_ok;
`ifdef MATSEQ_TRANSPOSE_EN
   logic tr;
`endif
   always_comb begin
      wr_row = wr_addr >= 4'd6 ? 2'd2 : wr_addr >= 4'd3 ? 2'd1 : 2'd0;
      wr_col = 2'(wr_addr - 4'(wr_row) * 4'd3);
      wr_ok = wr_en && state == IDLE && wr_addr <= 4'd8;
      ns = state;
      nk = k;
      ncnt = cnt;
      case (state)
         IDLE:    ns = start ? CLR : IDLE;
         CLR:     begin ns = STREAM; nk = 2'd0; end
         STREAM:  begin
            ns = k == 2'd2 ? (SETTLE == 0 ? DONE : SETL) : STREAM;
            nk = k == 2'd2 ? k : k + 2'd1;
            ncnt = 4'd0;
         end
         SETL:    begin
            ns = cnt == SET_LAST ? DONE : SETL;
            ncnt = cnt + 4'd1;
         end
         default: ns = IDLE;
      endcase
`ifdef MATSEQ_TRANSPOSE_EN
      nx1 = tr ? x[0][nk] : x[nk][0];
      nx2 = tr ? x[1][nk] : x[nk][1];
      nx3 = tr ? x[2][nk] : x[nk][2];
`else
      nx1 = x[nk][0];
      nx2 = x[nk][1];
      nx3 = x[nk][2];
`endif
   end
   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (clear) begin
         state <= IDLE;
         k <= 2'd0;
         cnt <= 4'd0;
         w <= '{default: '0};
         x <= '{default: '0};
         wr_err <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         mac_load <= 1'b0;
         mac_clear <= 1'b0;
         {data_w1, data_w2, data_w3, data_x1, data_x2, data_x3} <= '0;
`ifdef MATSEQ_TRANSPOSE_EN
         tr <= 1'b0;
`endif
      end else begin
         state <= ns;
         k <= nk;
         cnt <= ncnt;
         if (wr_ok && wr_sel) x[wr_row][wr_col] <= wr_data;
         if (wr_ok && !wr_sel) w[wr_row][wr_col] <= wr_data;
         wr_err <= wr_en && !wr_ok;
         busy <= ns != IDLE;
         done <= ns == DONE;
         mac_load <= ns == STREAM;
         mac_clear <= ns == CLR;
         data_w1 <= ns == STREAM ? w[0][nk] : '0;
         data_w2 <= ns == STREAM ? w[1][nk] : '0;
         data_w3 <= ns == STREAM ? w[2][nk] : '0;
         data_x1 <= ns == STREAM ? nx1 : '0;
         data_x2 <= ns == STREAM ? nx2 : '0;
         data_x3 <= ns == STREAM ? nx3 : '0;
`ifdef MATSEQ_TRANSPOSE_EN
         if (state == IDLE && start) tr <= x_transpose;
`endif
      end
   end
endmodule
